// File: rtl/uart_tx_param_pkg.sv
// Shared types and helpers for the parametrised UART transmitter (package uart_pkg).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Wide enough for both the data-bit index (up to 8) and the stop-bit index.
  localparam int unsigned IDX_W = 4;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 while enabled, ticks at terminal count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic fpga_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge fpga_clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

  assign bit_tick = enable && (cnt == TERM);
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stops.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             fpga_clk,
  input  logic             rst,
  uart_tx_param_if.slave   tx,
  output logic             sout,
  output logic             busy_tx,
  output logic             frame_done
);
  import uart_pkg::*;

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam logic ODD_PAR = (PARITY == 2);

  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shift, word_in;
  logic [IDX_W-1:0]     idx;
  logic                 par_bit;
  logic                 word_avail, load, shift_en, idx_clr, idx_inc, done_n, tick;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic        CHAIN = 1'b1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, full, empty;

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign tx.tx_ready = !rst && !full;
  assign push        = tx.tx_valid && tx.tx_ready;
  assign word_avail  = !empty;
  assign word_in     = mem[rd_ptr];

  always_ff @(posedge fpga_clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
`else
  localparam logic CHAIN = 1'b0;

  assign tx.tx_ready = !rst && (state == IDLE);
  assign word_avail  = tx.tx_valid;
  assign word_in     = tx.tx_data;
`endif

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .enable   (busy_tx),
    .bit_tick (tick)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (word_avail) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_clr = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idx_clr = 1'b1;
            state_n = (PARITY != 0) ? uart_pkg::PARITY : STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_n = STOP;
          idx_clr = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            // With a FIFO a queued word chains straight into the next START.
            if (CHAIN && word_avail) begin
              state_n = START;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      par_bit    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= done_n;
      if (load) begin
        shift   <= word_in;
        par_bit <= (^word_in) ^ ODD_PAR;
      end else if (shift_en) begin
        shift <= shift >> 1;
      end
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IDX_W'(1);
    end
  end

  assign busy_tx = (state != IDLE);

  always_comb begin
    sout = 1'b1;
    case (state)
      START:            sout = 1'b0;
      DATA:             sout = shift[0];
      uart_pkg::PARITY: sout = par_bit;
      default:          sout = 1'b1;
    endcase
  end
endmodule
